// File: rtl/dlx_pipe_ctrl.sv
// Pipelined DLX decode/control: ID decode, ID/EX-EX/MEM-MEM/WB control words, load-use stall, redirect flush.
// Optional macro ILLEGAL_TRAP_EN makes `illegal` sticky and freezes fetch until reset.
module dlx_pipe_ctrl #(
  parameter int OPW          = 6,
  parameter int FUNCTW       = 6,
  parameter int REGW         = 5,
  parameter int ALUOPW       = 6,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic [FUNCTW-1:0] funct,
  input  logic [REGW-1:0]   rs1,
  input  logic [REGW-1:0]   rs2,
  input  logic [REGW-1:0]   rd_r,
  input  logic [REGW-1:0]   rd_i,
  input  logic              branch_taken,
  input  logic              jump_taken,
  input  logic              jr_taken,
  output logic              id_branch,
  output logic              id_jump,
  output logic              id_jr,
  output logic [ALUOPW-1:0] ex_alu_op,
  output logic              ex_alu_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REGW-1:0]   wb_dest,
  output logic              stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              illegal
);

  localparam logic [ALUOPW-1:0] OP_ADD    = ALUOPW'(32'h20);
  localparam logic [ALUOPW-1:0] OP_JUMP   = ALUOPW'(32'h11);
  localparam logic [ALUOPW-1:0] OP_BRANCH = ALUOPW'(32'h22);
  localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES);

  typedef struct packed {
    logic [ALUOPW-1:0] alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REGW-1:0]   dest;
  } ex_word_t;

  logic [31:0]       op_u;
  logic [ALUOPW-1:0] funct_op;
  logic [ALUOPW-1:0] dec_alu_op;
  logic              dec_alu_src, dec_mem_read, dec_mem_write, dec_reg_write, dec_mem_to_reg;
  logic              dec_reg_dst, dec_branch, dec_jump, dec_jr;
  logic              dec_use_rs1, dec_use_rs2, dec_legal, dec_wr_en;
  logic [REGW-1:0]   dec_dest;
  logic              redirect, flushing, hazard, id_kill, bubble;

  ex_word_t          ex_d, ex_q;
  logic              mem_read_q, mem_write_q, mem_reg_write_q, mem_mem_to_reg_q;
  logic [REGW-1:0]   mem_dest_q;
  logic              wb_reg_write_q, wb_mem_to_reg_q;
  logic [REGW-1:0]   wb_dest_q;
  logic [2:0]        flush_cnt_d, flush_cnt_q;

  assign op_u = 32'(opcode);

  if (ALUOPW <= FUNCTW) begin : g_funct_trunc
    assign funct_op = funct[ALUOPW-1:0];
  end else begin : g_funct_ext
    assign funct_op = {{(ALUOPW-FUNCTW){1'b0}}, funct};
  end

  always_comb begin
    dec_alu_op     = '0;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_jr         = 1'b0;
    dec_use_rs1    = 1'b0;
    dec_use_rs2    = 1'b0;
    dec_legal      = 1'b1;
    if (op_u <= 32'd1) begin
      dec_alu_op    = funct_op;
      dec_reg_dst   = 1'b1;
      dec_reg_write = 1'b1;
      dec_use_rs1   = 1'b1;
      dec_use_rs2   = 1'b1;
    end else if (op_u inside {[32'd8:32'd14], [32'd20:32'd29]}) begin
      // Immediate forms reuse the R-type funct code of their register twin.
      if (op_u <= 32'd14)      dec_alu_op = ALUOPW'(op_u + 32'd24);
      else if (op_u <= 32'd23) dec_alu_op = ALUOPW'(op_u - 32'd16);
      else                     dec_alu_op = ALUOPW'(op_u + 32'd16);
      dec_alu_src   = 1'b1;
      dec_reg_write = 1'b1;
      dec_use_rs1   = 1'b1;
    end else if (op_u == 32'h23) begin
      dec_alu_op    = OP_ADD;
      dec_alu_src   = 1'b1;
      dec_mem_read  = 1'b1;
      dec_reg_write = 1'b1;
      dec_use_rs1   = 1'b1;
    end else if (op_u == 32'h2b) begin
      dec_alu_op    = OP_ADD;
      dec_alu_src   = 1'b1;
      dec_mem_write = 1'b1;
      dec_use_rs1   = 1'b1;
      dec_use_rs2   = 1'b1;
    end else if (op_u == 32'h02) begin
      dec_alu_op    = OP_JUMP;
      dec_jump      = 1'b1;
    end else if (op_u == 32'h12) begin
      dec_alu_op    = OP_JUMP;
      dec_jr        = 1'b1;
      dec_use_rs1   = 1'b1;
    end else if (op_u == 32'h04 || op_u == 32'h05) begin
      dec_alu_op    = OP_BRANCH;
      dec_branch    = 1'b1;
      dec_use_rs1   = 1'b1;
      dec_use_rs2   = (op_u == 32'h04);
    end else begin
      dec_legal     = 1'b0;
    end
  end

  assign dec_dest  = dec_legal ? (dec_reg_dst ? rd_r : rd_i) : '0;
  assign dec_wr_en = dec_reg_write && (dec_dest != '0);

  assign redirect = branch_taken | jump_taken | jr_taken;
  assign flushing = redirect | (flush_cnt_q != 3'd0);
  assign hazard   = ex_q.mem_read && (ex_q.dest != '0) &&
                    ((dec_use_rs1 && (ex_q.dest == rs1)) || (dec_use_rs2 && (ex_q.dest == rs2)));

`ifdef ILLEGAL_TRAP_EN
  logic           trap_q;
  logic [OPW-1:0] trap_opcode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (!trap_q && !dec_legal && !flushing) begin
      trap_q <= 1'b1;
    end
    if (!trap_q && !dec_legal && !flushing) begin
      trap_opcode_q <= opcode;
    end
  end

  assign id_kill = trap_q;
  assign stall   = trap_q | (hazard & ~flushing);
  assign illegal = trap_q | (~dec_legal & ~flushing);
`else
  assign id_kill = 1'b0;
  assign stall   = hazard & ~flushing;
  assign illegal = ~dec_legal;
`endif

  assign bubble    = stall | flushing | id_kill;
  assign id_branch = dec_branch & ~id_kill;
  assign id_jump   = dec_jump & ~id_kill;
  assign id_jr     = dec_jr & ~id_kill;
  assign if_flush  = flushing;
  assign id_flush  = redirect;
  assign ex_flush  = redirect;

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.alu_op     = dec_alu_op;
      ex_d.alu_src    = dec_alu_src;
      ex_d.mem_read   = dec_mem_read;
      ex_d.mem_write  = dec_mem_write;
      ex_d.reg_write  = dec_wr_en;
      ex_d.mem_to_reg = dec_mem_to_reg;
      ex_d.dest       = dec_dest;
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redirect)                  flush_cnt_d = FLUSH_LOAD;
    else if (flush_cnt_q != 3'd0)  flush_cnt_d = flush_cnt_q - 3'd1;
  end

  // ID/EX -> EX/MEM -> MEM/WB, one stage per clock
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q             <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_dest_q       <= '0;
      wb_reg_write_q   <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_dest_q        <= '0;
      flush_cnt_q      <= 3'd0;
    end else begin
      ex_q             <= ex_d;
      mem_read_q       <= ex_q.mem_read;
      mem_write_q      <= ex_q.mem_write;
      mem_reg_write_q  <= ex_q.reg_write;
      mem_mem_to_reg_q <= ex_q.mem_to_reg;
      mem_dest_q       <= ex_q.dest;
      wb_reg_write_q   <= mem_reg_write_q;
      wb_mem_to_reg_q  <= mem_mem_to_reg_q;
      wb_dest_q        <= mem_dest_q;
      flush_cnt_q      <= flush_cnt_d;
    end
  end

  assign ex_alu_op     = ex_q.alu_op;
  assign ex_alu_src    = ex_q.alu_src;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_dest       = wb_dest_q;

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Bench for dlx_pipe_ctrl (default build, FLUSH_CYCLES=2): directed scenarios plus random stimulus vs a delay-line model.
module tb_dlx_pipe_ctrl;
  localparam int FC = 2;

  logic       clk, reset;
  logic [5:0] opcode, funct;
  logic [4:0] rs1, rs2, rd_r, rd_i;
  logic       branch_taken, jump_taken, jr_taken;
  logic       id_branch, id_jump, id_jr, ex_alu_src, mem_read, mem_write;
  logic       wb_reg_write, wb_mem_to_reg, stall, if_flush, id_flush, ex_flush, illegal;
  logic [5:0] ex_alu_op;
  logic [4:0] wb_dest;

  dlx_pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rs1(rs1), .rs2(rs2),
    .rd_r(rd_r), .rd_i(rd_i), .branch_taken(branch_taken), .jump_taken(jump_taken),
    .jr_taken(jr_taken), .id_branch(id_branch), .id_jump(id_jump), .id_jr(id_jr),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest),
    .stall(stall), .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op;
    logic       src, mrd, mwr, rw, m2r;
    logic [4:0] dest;
  } cw_t;

  int    n_chk = 0;
  int    n_pass = 0;
  cw_t   m_ex = '0, m_mem = '0, m_wb = '0;
  int    m_fcnt = 0;
  cw_t   d_w;
  logic  d_b, d_j, d_jr, d_legal, d_u1, d_u2;
  logic  e_redirect, e_flushing, e_stall;
  logic [23:0] exp_vec;
  int    imm_hi [10] = '{'h04, 'h05, 'h06, 'h07, 'h28, 'h29, 'h2a, 'h2b, 'h2c, 'h2d};
  int    legal_ops [25] = '{0, 1, 8, 9, 10, 11, 12, 13, 14, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29,
                            35, 43, 2, 18, 4, 5};

  function automatic logic [23:0] obs_vec();
    return {ex_alu_op, ex_alu_src, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dest,
            id_branch, id_jump, id_jr, stall, if_flush, id_flush, ex_flush, illegal};
  endfunction

  task automatic model_decode();
    int op;
    int dst;
    op = int'(opcode);
    dst = int'(rd_i);
    d_w = '0; d_b = 0; d_j = 0; d_jr = 0; d_u1 = 0; d_u2 = 0; d_legal = 1;
    if (op == 0 || op == 1) begin
      d_w.op = funct; d_w.rw = 1; dst = int'(rd_r); d_u1 = 1; d_u2 = 1;
    end else if (op >= 8 && op <= 14) begin
      d_w.op = 6'('h20 + op - 8); d_w.src = 1; d_w.rw = 1; d_u1 = 1;
    end else if (op >= 20 && op <= 29) begin
      d_w.op = 6'(imm_hi[op-20]); d_w.src = 1; d_w.rw = 1; d_u1 = 1;
    end else if (op == 'h23) begin
      d_w.op = 6'h20; d_w.src = 1; d_w.mrd = 1; d_w.rw = 1; d_u1 = 1;
    end else if (op == 'h2b) begin
      d_w.op = 6'h20; d_w.src = 1; d_w.mwr = 1; d_u1 = 1; d_u2 = 1;
    end else if (op == 'h02) begin
      d_w.op = 6'h11; d_j = 1;
    end else if (op == 'h12) begin
      d_w.op = 6'h11; d_jr = 1; d_u1 = 1;
    end else if (op == 'h04 || op == 'h05) begin
      d_w.op = 6'h22; d_b = 1; d_u1 = 1; d_u2 = (op == 'h04);
    end else begin
      d_legal = 0;
    end
    if (d_legal) begin
      d_w.dest = 5'(dst);
      if (dst == 0) d_w.rw = 0;
    end
  endtask

  task automatic model_eval();
    logic hz;
    model_decode();
    e_redirect = branch_taken | jump_taken | jr_taken;
    e_flushing = e_redirect || (m_fcnt > 0);
    hz = m_ex.mrd && (m_ex.dest != 0) &&
         ((d_u1 && m_ex.dest == rs1) || (d_u2 && m_ex.dest == rs2));
    e_stall = hz && !e_flushing;
    exp_vec = {m_ex.op, m_ex.src, m_mem.mrd, m_mem.mwr, m_wb.rw, m_wb.m2r, m_wb.dest,
               d_b, d_j, d_jr, e_stall, e_flushing, e_redirect, e_redirect, ~d_legal};
  endtask

  task automatic model_commit();
    if (reset) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_fcnt = 0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (e_stall || e_flushing) ? '0 : d_w;
      m_fcnt = e_redirect ? FC : (m_fcnt > 0 ? m_fcnt - 1 : 0);
    end
  endtask

  task automatic settle();
    #3;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int op, input int fn, input int r1, input int r2, input int rr, input int ri);
    opcode = 6'(op); funct = 6'(fn); rs1 = 5'(r1); rs2 = 5'(r2); rd_r = 5'(rr); rd_i = 5'(ri);
  endtask

  task automatic set_taken(input logic b, input logic j, input logic jr);
    branch_taken = b; jump_taken = j; jr_taken = jr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_in($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31));
      set_taken(1'($urandom), 1'($urandom), 1'($urandom));
      settle();
      n_chk++;
      if (obs_vec() !== exp_vec) $display("FAIL reset_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      else n_pass++;
      advance();
    end
    set_in(0, 0, 0, 0, 0, 0);
    set_taken(0, 0, 0);
    settle();
    n_chk++;
    if ({ex_alu_op, ex_alu_src, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dest} !== 16'h0)
      $display("FAIL reset_regs got=%h exp=0000",
               {ex_alu_op, ex_alu_src, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dest});
    else n_pass++;
    advance();
    reset = 1'b0;
    settle();
    n_chk++;
    if (if_flush !== 1'b0) $display("FAIL reset_counter if_flush got=%b exp=0", if_flush);
    else n_pass++;
    advance();
  endtask

  task automatic test_addi();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) set_in('h08, $urandom_range(0, 63), 1, 2, 7, 3);
      else        set_in(0, 0, 0, 0, 0, 0);
      settle();
      n_chk++;
      if (obs_vec() !== exp_vec) $display("FAIL addi_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 1) begin
        n_chk++;
        if ({ex_alu_op, ex_alu_src} !== {6'h20, 1'b1})
          $display("FAIL addi_ex got=%h/%b exp=20/1", ex_alu_op, ex_alu_src);
        else n_pass++;
      end
      if (c == 3) begin
        n_chk++;
        if ({wb_reg_write, wb_dest} !== {1'b1, 5'd3})
          $display("FAIL addi_wb got=%b/%0d exp=1/3", wb_reg_write, wb_dest);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      set_in('h23, 0, 2, 0, 0, 5);
      else if (c <= 2) set_in(0, 'h20, 5, 6, 7, 0);
      else             set_in(0, 0, 0, 0, 0, 0);
      settle();
      n_chk++;
      if (obs_vec() !== exp_vec) $display("FAIL loaduse_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 1 || c == 2) begin
        n_chk++;
        if (stall !== (c == 1)) $display("FAIL loaduse_stall c=%0d got=%b exp=%b", c, stall, (c == 1));
        else n_pass++;
      end
      if (c == 2 || c == 3) begin
        n_chk++;
        if (ex_alu_op !== ((c == 3) ? 6'h20 : 6'h00))
          $display("FAIL loaduse_ex c=%0d got=%h exp=%h", c, ex_alu_op, (c == 3) ? 6'h20 : 6'h00);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_load_r0();
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      set_in('h23, 0, 1, 0, 0, 0);
      else if (c == 1) set_in(0, 'h20, 0, 0, 4, 0);
      else             set_in(0, 0, 0, 0, 0, 0);
      settle();
      n_chk++;
      if (obs_vec() !== exp_vec) $display("FAIL r0_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 1) begin
        n_chk++;
        if (stall !== 1'b0) $display("FAIL r0_stall got=%b exp=0", stall);
        else n_pass++;
      end
      if (c == 3) begin
        n_chk++;
        if (wb_reg_write !== 1'b0) $display("FAIL r0_wb got=%b exp=0", wb_reg_write);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 7; c++) begin
      set_in('h08, 0, 1, 0, 0, 9);
      set_taken(c == 0, 0, 0);
      settle();
      n_chk++;
      if (obs_vec() !== exp_vec) $display("FAIL flush_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      else n_pass++;
      n_chk++;
      if ({if_flush, id_flush, ex_flush} !== {(c <= 2), (c == 0), (c == 0)})
        $display("FAIL flush_flags c=%0d got=%b%b%b exp=%b%b%b", c, if_flush, id_flush, ex_flush,
                 (c <= 2), (c == 0), (c == 0));
      else n_pass++;
      if (c >= 3) begin
        n_chk++;
        if (wb_reg_write !== (c == 6)) $display("FAIL flush_wb c=%0d got=%b exp=%b", c, wb_reg_write, (c == 6));
        else n_pass++;
      end
      advance();
    end
    set_taken(0, 0, 0);
  endtask

  task automatic test_illegal();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_in('h3f, $urandom_range(0, 63), 1, 2, 4, 4);
      else        set_in(0, 0, 0, 0, 0, 0);
      settle();
      n_chk++;
      if (obs_vec() !== exp_vec) $display("FAIL illegal_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      else n_pass++;
      n_chk++;
      if (illegal !== (c == 0)) $display("FAIL illegal_flag c=%0d got=%b exp=%b", c, illegal, (c == 0));
      else n_pass++;
      if (c == 1) begin
        n_chk++;
        if ({ex_alu_op, ex_alu_src} !== 7'h0) $display("FAIL illegal_ex got=%h exp=00", {ex_alu_op, ex_alu_src});
        else n_pass++;
      end
      if (c == 3) begin
        n_chk++;
        if ({wb_reg_write, wb_dest} !== 6'h0) $display("FAIL illegal_wb got=%h exp=00", {wb_reg_write, wb_dest});
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      set_in('h23, 0, 1, 0, 0, 5);
      else if (c <= 2) set_in(0, 'h20, 5, 6, 7, 0);
      else             set_in(0, 0, 0, 0, 0, 0);
      reset = (c == 2);
      set_taken(0, c == 2, 0);
      settle();
      n_chk++;
      if (obs_vec() !== exp_vec) $display("FAIL rstmid_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 1) begin
        n_chk++;
        if (stall !== 1'b1) $display("FAIL rstmid_stall got=%b exp=1", stall);
        else n_pass++;
      end
      if (c == 2) begin
        n_chk++;
        if (if_flush !== 1'b1) $display("FAIL rstmid_comb if_flush got=%b exp=1", if_flush);
        else n_pass++;
      end
      if (c == 3) begin
        n_chk++;
        if ({ex_alu_op, ex_alu_src, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dest, if_flush} !== 17'h0)
          $display("FAIL rstmid_regs got=%h exp=00000",
                   {ex_alu_op, ex_alu_src, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dest, if_flush});
        else n_pass++;
      end
      advance();
    end
    reset = 1'b0;
    set_taken(0, 0, 0);
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) != 0) r = legal_ops[$urandom_range(0, 24)];
      else                           r = $urandom_range(0, 63);
      set_in(r, $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
      r = $urandom_range(0, 15);
      set_taken(r == 0, r == 1, r == 2);
      reset = ($urandom_range(0, 63) == 0);
      settle();
      n_chk++;
      if (obs_vec() !== exp_vec) $display("FAIL random_vec c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      else n_pass++;
      advance();
    end
    reset = 1'b0;
    set_taken(0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    set_taken(0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_load_use();
    test_load_r0();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
